pulse_decoder: RTL and testbench

//  Receive end of the switch-coded pulse link. Measures the width of each high pulse on

---
 rtl/pulse_link_pkg.sv | 25 ++
 rtl/pulse_tick_gen.sv | 27 ++
 rtl/pulse_decoder.sv | 144 ++++++++++++++
 tb/tb_pulse_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_link_pkg.sv
// Shared constants for the switch-coded pulse link: switch weights,
// the 16-entry subset-sum table and the receiver FSM state encoding.
package pulse_link_pkg;

  localparam int W1 = 131;
  localparam int W2 = 120;
  localparam int W3 = 87;
  localparam int W4 = 54;

  // Coded high width (in ticks, before OFFSET) for each switch code {sw4,sw3,sw2,sw1}
  localparam logic [8:0] CODE_SUM [16] = '{
    9'd0,   9'd131, 9'd120, 9'd251,
    9'd87,  9'd218, 9'd207, 9'd338,
    9'd54,  9'd185, 9'd174, 9'd305,
    9'd141, 9'd272, 9'd261, 9'd392
  };

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEASURE  = 2'd2,
    DECODE   = 2'd3
  } state_e;

endpackage

// File: rtl/pulse_tick_gen.sv
// Baud tick divider: tick is high for one sysclk each time the counter
// wraps from DIV-1 back to 0.
module pulse_tick_gen #(
  parameter int DIV      = 5207,
  parameter int DIV_BITS = 15
) (
  input  logic sysclk,
  input  logic rst,
  output logic tick
);

  logic [DIV_BITS-1:0] div_q;
  logic [DIV_BITS-1:0] div_d;

  // Wrap detection and next divider value
  always_comb begin
    tick  = (div_q == DIV_BITS'(DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Divider register
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

endmodule

// File: rtl/pulse_decoder.sv
// Receive end of the pulse link: measures each high pulse on line_in in
// baud ticks and maps the width back to a 4-bit switch code.
// valid/err are single-sysclk pulses and are mutually exclusive.
module pulse_decoder
  import pulse_link_pkg::*;
#(
  parameter int DIV       = 5207,
  parameter int DIV_BITS  = 15,
  parameter int OFFSET    = 1,
  parameter int TOL       = 4,
  parameter int MIN_TICKS = 8,
  parameter int MAX_TICKS = 480
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       line_in,
  output logic [3:0] code,
  output logic [8:0] width,
  output logic       valid,
  output logic       err,
  output logic       busy,
  output logic [1:0] state_dbg
);

  logic tick;

  pulse_tick_gen #(.DIV(DIV), .DIV_BITS(DIV_BITS)) u_tick (
    .sysclk (sysclk),
    .rst    (rst),
    .tick   (tick)
  );

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [3:0] code_q, code_d;
  logic [8:0] width_q, width_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       sync1_q, sync2_q;

  logic signed [9:0] t_val;
  logic signed [9:0] diff [16];
  logic              match_found;
  logic [3:0]        match_code;

  // Two-flop synchroniser for the asynchronous line
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
    end
  end

  // Parallel tolerance comparators; descending scan so the lowest k wins
  always_comb begin
    t_val       = $signed({1'b0, cnt_q}) - $signed(10'(OFFSET));
    match_found = 1'b0;
    match_code  = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      diff[k] = t_val - $signed({1'b0, CODE_SUM[k]});
      if ((diff[k] <= $signed(10'(TOL))) && (diff[k] >= -$signed(10'(TOL)))) begin
        match_found = 1'b1;
        match_code  = 4'(k);
      end
    end
  end

  // FSM next state; only DECODE advances without a tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    width_d = width_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      WAIT_LOW: if (tick && !sync2_q) state_d = IDLE;
      IDLE: begin
        if (tick && sync2_q) begin
          state_d = MEASURE;
          cnt_d   = 9'd1;
        end
      end
      MEASURE: begin
        if (tick) begin
          if (sync2_q) begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_d >= 9'(MAX_TICKS)) begin
              cnt_d   = 9'(MAX_TICKS);
              width_d = 9'(MAX_TICKS);
              err_d   = 1'b1;
              state_d = WAIT_LOW;
            end
          end else if (cnt_q < 9'(MIN_TICKS)) begin
            state_d = IDLE;
          end else begin
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        width_d = cnt_q;
        if (match_found) begin
          code_d  = match_code;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOW;
      cnt_q   <= '0;
      code_q  <= '0;
      width_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      width_q <= width_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign code      = code_q;
  assign width     = width_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign busy      = (state_q == MEASURE) || (state_q == DECODE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_decoder.sv
// Bench for pulse_decoder with DIV=4. Expected results are queued as
// {kind[1:0], code[3:0], width[8:0]} (kind 01=valid, 10=err) when a pulse is
// driven; a negedge monitor pops and compares each DUT output event.
module tb_pulse_decoder;

  localparam int DIV = 4;
  localparam int SW  = 15;

  logic       sysclk;
  logic       rst;
  logic       line_in;
  logic [3:0] code;
  logic [8:0] width;
  logic       valid;
  logic       err;
  logic       busy;
  logic [1:0] state_dbg;

  int pass_cnt;
  int total_cnt;
  logic [SW-1:0] exp_q[$];
  logic [3:0]    model_code;

  pulse_decoder #(.DIV(DIV), .DIV_BITS(15)) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .line_in   (line_in),
    .code      (code),
    .width     (width),
    .valid     (valid),
    .err       (err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // ---------------- scoreboard monitor ----------------
  always @(negedge sysclk) begin
    logic [SW-1:0] obs;
    logic [SW-1:0] e;
    if (!rst && (valid || err)) begin
      obs = {err, valid, code, width};
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL output_event: unexpected kind=%b code=%b width=%0d", obs[14:13], code, width);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e)
          $display("FAIL output_event: got kind=%b code=%b width=%0d, want kind=%b code=%b width=%0d",
                   obs[14:13], obs[12:9], obs[8:0], e[14:13], e[12:9], e[8:0]);
        else
          pass_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int code_sum(input int k);
    int s;
    s = 0;
    if (k[0]) s += 131;
    if (k[1]) s += 120;
    if (k[2]) s += 87;
    if (k[3]) s += 54;
    return s;
  endfunction

  task automatic push_expect(input int n);
    int t;
    int hit;
    if (n < 8) return;
    if (n >= 480) begin
      exp_q.push_back({2'b10, model_code, 9'd480});
      return;
    end
    t   = n - 1;
    hit = -1;
    for (int k = 15; k >= 0; k--)
      if ((t - code_sum(k) <= 4) && (code_sum(k) - t <= 4)) hit = k;
    if (hit >= 0) begin
      model_code = 4'(hit);
      exp_q.push_back({2'b01, model_code, 9'(n)});
    end else begin
      exp_q.push_back({2'b10, model_code, 9'(n)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic hold_line(input logic lvl, input int ticks);
    @(negedge sysclk);
    line_in = lvl;
    repeat (ticks * DIV - 1) @(negedge sysclk);
  endtask

  task automatic send_pulse(input int n, input int low_ticks);
    push_expect(n);
    hold_line(1'b1, n);
    hold_line(1'b0, low_ticks);
  endtask

  task automatic check_drained(input string name);
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s: %0d expected outputs never appeared, want 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      pass_cnt++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst     = 1'b1;
    line_in = 1'b0;
    repeat (3) @(negedge sysclk);
    total_cnt++;
    if ({code, width, valid, err, busy} !== 16'd0)
      $display("FAIL reset_outputs: got code=%b width=%0d valid=%b err=%b busy=%b, want all 0",
               code, width, valid, err, busy);
    else pass_cnt++;
    total_cnt++;
    if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_dbg);
    else pass_cnt++;
    rst = 1'b0;
    model_code = 4'd0;
  endtask

  task automatic test_basic;
    hold_line(1'b0, 5);
    push_expect(132);
    hold_line(1'b1, 60);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_measure: got %b want 1", busy);
    else pass_cnt++;
    hold_line(1'b1, 72);
    hold_line(1'b0, 10);
    check_drained("basic_132");
    total_cnt++;
    if (code !== 4'b0001) $display("FAIL basic_code: got %b want 0001", code);
    else pass_cnt++;
  endtask

  task automatic test_extremes;
    send_pulse(393, 10);
    check_drained("max_code_393");
    send_pulse(56, 10);
    check_drained("code_56");
    total_cnt++;
    if (code !== 4'b1000) $display("FAIL code_56_held: got %b want 1000", code);
    else pass_cnt++;
  endtask

  task automatic test_no_match;
    send_pulse(137, 10);
    check_drained("no_match_137");
    total_cnt++;
    if (code !== 4'b1000) $display("FAIL err_code_held: got %b want 1000", code);
    else pass_cnt++;
    total_cnt++;
    if (width !== 9'd137) $display("FAIL err_width: got %0d want 137", width);
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    send_pulse(3, 10);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", busy);
    else pass_cnt++;
    check_drained("glitch_3");
    send_pulse(7, 10);
    check_drained("glitch_7");
    send_pulse(8, 10);
    check_drained("min_8_err");
    send_pulse(121, 10);
    check_drained("code_121");
    total_cnt++;
    if (code !== 4'b0010) $display("FAIL code_121_out: got %b want 0010", code);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pulse;
    hold_line(1'b1, 50);
    @(negedge sysclk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({code, width, valid, err, busy} !== 16'd0)
      $display("FAIL midreset_outputs: got code=%b width=%0d valid=%b err=%b busy=%b, want all 0",
               code, width, valid, err, busy);
    else pass_cnt++;
    model_code = 4'd0;
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
    hold_line(1'b1, 100);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy);
    else pass_cnt++;
    hold_line(1'b0, 10);
    check_drained("midreset_silent");
    send_pulse(88, 10);
    check_drained("code_88");
  endtask

  task automatic test_overflow;
    send_pulse(479, 10);
    check_drained("width_479_err");
    send_pulse(600, 10);
    check_drained("overflow_600");
    total_cnt++;
    if (width !== 9'd480) $display("FAIL overflow_width: got %0d want 480", width);
    else pass_cnt++;
    send_pulse(219, 10);
    check_drained("code_219");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = $urandom_range(1, 15);
      send_pulse(code_sum(k) + 1 + $urandom_range(0, 8) - 4, $urandom_range(2, 6));
    end
    hold_line(1'b0, 6);
    check_drained("back_to_back");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    model_code = 4'd0;
    test_reset();
    test_basic();
    test_extremes();
    test_no_match();
    test_glitch();
    test_reset_mid_pulse();
    test_overflow();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
